uart_parity_engine: RTL and testbench

- Parametrised parity unit for the UART datapath, replacing the fixed 8-bit combinational parity generator.
- TX path: registers the parity of a loaded word under a runtime-selectable parity mode.
- RX path: accumulates parity serially as data bits arrive from the receiver shift logic. It then checks the received parity bit and raises a pulse error and a sticky error.
- Sits between the UART TX/RX framers and the status register block.

---
 rtl/uart_parity_engine.sv | 142 ++++++++++++++
 tb/tb_uart_parity_engine.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_parity_engine.sv
// Parameterised UART parity unit: registered TX parity generator and a serial
// RX parity checker with a per-frame error pulse and a sticky error flag.
module uart_parity_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            parity_mode,
    input  logic                  load_data,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  PARITY_BIT,
    output logic                  parity_valid,
    input  logic                  rx_start,
    input  logic                  rx_bit_valid,
    input  logic                  rx_bit,
    output logic                  rx_done,
    output logic                  parity_err,
    output logic                  parity_err_sticky,
    input  logic                  err_clr,
    output logic                  rx_busy
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        DONE
    } rx_state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // Modes 0 and 5..7 all mean "no parity bit on the line".
    function automatic logic mode_is_none(input logic [2:0] mode);
        return (mode == 3'd0) || (mode > 3'd4);
    endfunction

    // x is the XOR of the data bits; result is the parity bit for that mode.
    function automatic logic parity_of(input logic x, input logic [2:0] mode);
        logic p;
        case (mode)
            3'd1:    p = x;
            3'd2:    p = ~x;
            3'd3:    p = 1'b1;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    // ---------------- TX path ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PARITY_BIT   <= 1'b0;
            parity_valid <= 1'b0;
        end else begin
            parity_valid <= load_data;
            if (load_data) begin
                PARITY_BIT <= parity_of(^TX_DATA, parity_mode);
            end
        end
    end

    // ---------------- RX path ----------------
    rx_state_t        state, state_n;
    logic             acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       mode_r, mode_n;
    logic             err, err_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= 1'b0;
            cnt    <= '0;
            mode_r <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            mode_r <= mode_n;
            err    <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        mode_n  = mode_r;
        err_n   = err;

        // A start strobe in any state begins a fresh frame and drops any partial one.
        if (rx_start) begin
            state_n = DATA;
            acc_n   = 1'b0;
            cnt_n   = '0;
            mode_n  = parity_mode;
            err_n   = 1'b0;
        end else begin
            case (state)
                DATA: begin
                    if (rx_bit_valid) begin
                        acc_n = acc ^ rx_bit;
                        cnt_n = cnt + CNT_W'(1);
                        if (cnt == LAST_BIT) begin
                            if (mode_is_none(mode_r)) begin
                                state_n = DONE;
                                err_n   = 1'b0;
                            end else begin
                                state_n = PARITY;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (rx_bit_valid) begin
                        err_n   = (rx_bit != parity_of(acc, mode_r));
                        state_n = DONE;
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_sticky <= 1'b0;
        end else if ((state == DONE) && err) begin
            parity_err_sticky <= 1'b1;
        end else if (err_clr) begin
            parity_err_sticky <= 1'b0;
        end
    end

    assign rx_done    = (state == DONE);
    assign parity_err = (state == DONE) && err;
    assign rx_busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_parity_engine.sv
// Directed bench for uart_parity_engine: three instances (DATA_WIDTH 5, 8, 9)
// share TX stimulus; each RX path is exercised in turn via its own rx_start.
module tb_uart_parity_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] parity_mode;
    logic       load_data;
    logic [8:0] tx_data;
    logic [2:0] rx_start;
    logic       rx_bit_valid;
    logic       rx_bit;
    logic       err_clr;

    logic [2:0] pbit, pvalid, rdone, perr, psticky, rbusy;

    int total = 0;
    int bad   = 0;
    int W [3];

    always #5 clk = ~clk;

    uart_parity_engine #(.DATA_WIDTH(5), .CNT_W(4)) dut5 (
        .clk(clk), .rst(rst), .parity_mode(parity_mode), .load_data(load_data),
        .TX_DATA(tx_data[4:0]), .PARITY_BIT(pbit[0]), .parity_valid(pvalid[0]),
        .rx_start(rx_start[0]), .rx_bit_valid(rx_bit_valid), .rx_bit(rx_bit),
        .rx_done(rdone[0]), .parity_err(perr[0]), .parity_err_sticky(psticky[0]),
        .err_clr(err_clr), .rx_busy(rbusy[0])
    );

    uart_parity_engine #(.DATA_WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst), .parity_mode(parity_mode), .load_data(load_data),
        .TX_DATA(tx_data[7:0]), .PARITY_BIT(pbit[1]), .parity_valid(pvalid[1]),
        .rx_start(rx_start[1]), .rx_bit_valid(rx_bit_valid), .rx_bit(rx_bit),
        .rx_done(rdone[1]), .parity_err(perr[1]), .parity_err_sticky(psticky[1]),
        .err_clr(err_clr), .rx_busy(rbusy[1])
    );

    uart_parity_engine #(.DATA_WIDTH(9), .CNT_W(4)) dut9 (
        .clk(clk), .rst(rst), .parity_mode(parity_mode), .load_data(load_data),
        .TX_DATA(tx_data[8:0]), .PARITY_BIT(pbit[2]), .parity_valid(pvalid[2]),
        .rx_start(rx_start[2]), .rx_bit_valid(rx_bit_valid), .rx_bit(rx_bit),
        .rx_done(rdone[2]), .parity_err(perr[2]), .parity_err_sticky(psticky[2]),
        .err_clr(err_clr), .rx_busy(rbusy[2])
    );

    typedef struct {
        logic [2:0] mode;
        logic [8:0] data;
        logic [2:0] exp;   // expected PARITY_BIT per instance: bit0=W5, bit1=W8, bit2=W9
    } tx_vec_t;

    tx_vec_t tx_tab [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int k, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [W=%0d] got=%b want=%b at %0t", name, W[k], act, exp, $time);
        end
    endtask

    function automatic logic ref_par(input int w, input logic [8:0] d, input logic [2:0] m);
        int ones = 0;
        for (int i = 0; i < w; i++) ones += int'(d[i]);
        case (m)
            3'd1:    return ones[0];
            3'd2:    return ~ones[0];
            3'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Runs one full frame on instance k; parity bit is the correct one XOR flip.
    task automatic run_frame(input int k, input logic [2:0] mode, input logic [8:0] data,
                             input logic flip, input logic clr_at_done);
        int   w    = W[k];
        logic none = (mode == 3'd0) || (mode > 3'd4);
        parity_mode = mode;
        rx_start[k] = 1'b1;
        step();
        rx_start    = '0;
        // Scramble the live mode: the frame must keep using the latched one.
        parity_mode = none ? 3'd2 : 3'd0;
        check("busy_after_start", k, rbusy[k], 1'b1);
        for (int i = 0; i < w; i++) begin
            rx_bit_valid = 1'b1;
            rx_bit       = data[i];
            step();
            if (i < w - 1) check("done_early", k, rdone[k], 1'b0);
        end
        if (!none) begin
            check("done_before_parity", k, rdone[k], 1'b0);
            rx_bit = ref_par(w, data, mode) ^ flip;
            step();
        end
        rx_bit_valid = 1'b0;
        rx_bit       = 1'b0;
        err_clr      = clr_at_done;
        check("rx_done", k, rdone[k], 1'b1);
        check("parity_err", k, perr[k], flip & ~none);
        step();
        err_clr = 1'b0;
        check("rx_done_pulse", k, rdone[k], 1'b0);
        check("parity_err_pulse", k, perr[k], 1'b0);
        check("busy_idle", k, rbusy[k], 1'b0);
    endtask

    initial begin
        logic [2:0] prev;
        W[0] = 5; W[1] = 8; W[2] = 9;

        tx_tab[0]  = '{3'd1, 9'h0A7, 3'b111};
        tx_tab[1]  = '{3'd2, 9'h0A7, 3'b000};
        tx_tab[2]  = '{3'd3, 9'h000, 3'b111};
        tx_tab[3]  = '{3'd4, 9'h000, 3'b000};
        tx_tab[4]  = '{3'd3, 9'h000, 3'b111};
        tx_tab[5]  = '{3'd1, 9'h000, 3'b000};
        tx_tab[6]  = '{3'd3, 9'h0FF, 3'b111};
        tx_tab[7]  = '{3'd6, 9'h000, 3'b000};
        tx_tab[8]  = '{3'd1, 9'h1FF, 3'b101};
        tx_tab[9]  = '{3'd2, 9'h1FF, 3'b010};
        tx_tab[10] = '{3'd0, 9'h1FF, 3'b000};
        tx_tab[11] = '{3'd1, 9'h103, 3'b100};
        tx_tab[12] = '{3'd7, 9'h0FF, 3'b000};

        rst = 1'b1; parity_mode = '0; load_data = 1'b0; tx_data = '0;
        rx_start = '0; rx_bit_valid = 1'b0; rx_bit = 1'b0; err_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            check("rst_parity_bit", k, pbit[k], 1'b0);
            check("rst_parity_valid", k, pvalid[k], 1'b0);
            check("rst_rx_done", k, rdone[k], 1'b0);
            check("rst_parity_err", k, perr[k], 1'b0);
            check("rst_sticky", k, psticky[k], 1'b0);
            check("rst_busy", k, rbusy[k], 1'b0);
        end

        // TX vector table: load one cycle, then an idle cycle with scrambled inputs.
        for (int v = 0; v < 13; v++) begin
            parity_mode = tx_tab[v].mode;
            tx_data     = tx_tab[v].data;
            load_data   = 1'b1;
            step();
            load_data   = 1'b0;
            tx_data     = ~tx_tab[v].data;
            parity_mode = 3'd3;
            for (int k = 0; k < 3; k++) begin
                check("tx_valid", k, pvalid[k], 1'b1);
                check("tx_parity", k, pbit[k], tx_tab[v].exp[k]);
            end
            step();
            for (int k = 0; k < 3; k++) begin
                check("tx_valid_pulse", k, pvalid[k], 1'b0);
                check("tx_parity_hold", k, pbit[k], tx_tab[v].exp[k]);
            end
        end

        // Back-to-back loads each produce a pulse.
        parity_mode = 3'd1; tx_data = 9'h0A7; load_data = 1'b1;
        step();
        prev = pbit;
        parity_mode = 3'd2;
        step();
        load_data = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("b2b_first", k, prev[k], 1'b1);
            check("b2b_valid", k, pvalid[k], 1'b1);
            check("b2b_second", k, pbit[k], 1'b0);
        end
        step();
        for (int k = 0; k < 3; k++) check("b2b_valid_end", k, pvalid[k], 1'b0);

        for (int k = 0; k < 3; k++) begin
            // Good odd frame.
            run_frame(k, 3'd2, 9'h03C, 1'b0, 1'b0);
            check("sticky_clean", k, psticky[k], 1'b0);
            // Bad even frame: 0x01 with parity 0.
            run_frame(k, 3'd1, 9'h001, 1'b1, 1'b0);
            check("sticky_set", k, psticky[k], 1'b1);
            run_frame(k, 3'd1, 9'h03C, 1'b0, 1'b0);
            check("sticky_hold", k, psticky[k], 1'b1);
            err_clr = 1'b1;
            step();
            err_clr = 1'b0;
            check("sticky_clr", k, psticky[k], 1'b0);
            // err_clr coincident with a new error: set wins.
            run_frame(k, 3'd3, 9'h055, 1'b1, 1'b1);
            check("sticky_set_wins", k, psticky[k], 1'b1);
            err_clr = 1'b1;
            step();
            err_clr = 1'b0;
            // Mark/space frames and mode none (5 also means none).
            run_frame(k, 3'd4, 9'h1A5, 1'b0, 1'b0);
            run_frame(k, 3'd0, 9'h055, 1'b0, 1'b0);
            run_frame(k, 3'd5, 9'h1FF, 1'b0, 1'b0);
            check("sticky_after_good", k, psticky[k], 1'b0);

            // Restart after 3 ones: stale bits would flip the parity.
            parity_mode = 3'd1;
            rx_start[k] = 1'b1;
            step();
            rx_start = '0;
            for (int i = 0; i < 3; i++) begin
                rx_bit_valid = 1'b1; rx_bit = 1'b1;
                step();
            end
            rx_bit_valid = 1'b0;
            check("restart_busy", k, rbusy[k], 1'b1);
            check("restart_no_done", k, rdone[k], 1'b0);
            run_frame(k, 3'd1, 9'h0F0, 1'b0, 1'b0);

            // Reset mid-frame.
            parity_mode = 3'd2;
            rx_start[k] = 1'b1;
            step();
            rx_start = '0;
            for (int i = 0; i < 4; i++) begin
                rx_bit_valid = 1'b1; rx_bit = i[0];
                step();
            end
            rx_bit_valid = 1'b0;
            rst = 1'b1;
            #2;
            check("rst_mid_busy", k, rbusy[k], 1'b0);
            check("rst_mid_done", k, rdone[k], 1'b0);
            rst = 1'b0;
            step();
            check("post_rst_done", k, rdone[k], 1'b0);
            run_frame(k, 3'd2, 9'h13C, 1'b0, 1'b0);
            run_frame(k, 3'd2, 9'h13C, 1'b1, 1'b0);
            check("post_rst_sticky", k, psticky[k], 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
